unidade_controle_jogo: RTL

Control unit for the werewolf game. It drives every control strobe of the game datapath (seed select, night actions, elimination, day vote) and sequences the night/day rounds from the datapath's status flags and the player's confirm pulse. It sits between the button front-end (edge-detected pulses) and the game datapath, and decides when the village or the wolf has won.

---
 rtl/unidade_controle_jogo.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/unidade_controle_jogo.sv
// Werewolf game control unit: Moore FSM sequencing night actions, elimination and day vote.
// Optional choice-state timeout is enabled by defining TIMEOUT_EN.
module unidade_controle_jogo #(
    parameter int unsigned TIMEOUT_CICLOS = 50_000_000,
    parameter int unsigned TW             = 26
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       iniciar,
    input  logic       confirmar,
    input  logic       CJ_fim,
    input  logic       jogador_vivo,
    input  logic       jogou,
    input  logic       votou,
    input  logic       acertou,
    input  logic       sinal_lobo_ganhou,
    output logic       rst_global,
    output logic       zera_CS,
    output logic       zera_CJ,
    output logic       inc_seed,
    output logic       e_seed_reg,
    output logic       inc_jogador,
    output logic       mostra_classe,
    output logic       processar_acao,
    output logic       avaliar_eliminacao,
    output logic       voto,
    output logic       morra,
    output logic       reset_Pular,
    output logic       fim_jogo,
    output logic       vila_ganhou,
    output logic       lobo_ganhou,
    output logic       timeout,
    output logic [4:0] db_estado
);

    typedef enum logic [4:0] {
        INICIAL       = 5'd0,
        OCIOSO        = 5'd1,
        SEMENTE       = 5'd2,
        NOITE_MOSTRA  = 5'd3,
        NOITE_ACAO    = 5'd4,
        NOITE_CHECA   = 5'd5,
        NOITE_PROXIMO = 5'd6,
        ELIMINA       = 5'd7,
        CHECA_NOITE   = 5'd8,
        VOTACAO       = 5'd9,
        REGISTRA_VOTO = 5'd10,
        CHECA_VOTO    = 5'd11,
        APLICA_VOTO   = 5'd12,
        LIMPA_PULAR   = 5'd13,
        AVALIA_DIA    = 5'd14,
        NOVA_NOITE    = 5'd15,
        FIM_VILA      = 5'd16,
        FIM_LOBO      = 5'd17
    } estado_t;

    estado_t estado_q, estado_d;
    logic    tmo_hit_c;
    logic    tmo_fire_c;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

`ifdef TIMEOUT_EN
    logic [TW-1:0] cnt_q, cnt_d;
    logic          timeout_q;

    // Cycle counter is zero on entry to a choice state because every predecessor is a non-choice state
    always_comb begin
        cnt_d = '0;
        if (estado_q == NOITE_MOSTRA || estado_q == VOTACAO) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= tmo_fire_c;
        end
    end

    assign tmo_hit_c = (cnt_q == TW'(TIMEOUT_CICLOS - 1));
    assign timeout   = timeout_q;
`else
    logic [TW:0] unused_cfg;

    assign tmo_hit_c  = 1'b0;
    assign timeout    = 1'b0;
    assign unused_cfg = {TW'(TIMEOUT_CICLOS), tmo_fire_c};
`endif

    // Next-state logic
    always_comb begin
        estado_d   = estado_q;
        tmo_fire_c = 1'b0;
        unique case (estado_q)
            INICIAL:       estado_d = OCIOSO;
            OCIOSO:        if (iniciar) estado_d = SEMENTE;
            SEMENTE:       estado_d = NOITE_MOSTRA;
            NOITE_MOSTRA: begin
                if (!jogador_vivo) begin
                    estado_d = NOITE_PROXIMO;
                end else if (confirmar) begin
                    estado_d = NOITE_ACAO;
                end else if (tmo_hit_c) begin
                    estado_d   = NOITE_PROXIMO;
                    tmo_fire_c = 1'b1;
                end
            end
            NOITE_ACAO:    estado_d = NOITE_CHECA;
            NOITE_CHECA:   estado_d = jogou ? NOITE_PROXIMO : NOITE_MOSTRA;
            NOITE_PROXIMO: estado_d = CJ_fim ? ELIMINA : NOITE_MOSTRA;
            ELIMINA:       estado_d = CHECA_NOITE;
            CHECA_NOITE:   estado_d = sinal_lobo_ganhou ? FIM_LOBO : VOTACAO;
            VOTACAO: begin
                if (confirmar) begin
                    estado_d = REGISTRA_VOTO;
                end else if (tmo_hit_c) begin
                    estado_d   = NOVA_NOITE;
                    tmo_fire_c = 1'b1;
                end
            end
            REGISTRA_VOTO: estado_d = CHECA_VOTO;
            CHECA_VOTO:    estado_d = votou ? APLICA_VOTO : VOTACAO;
            APLICA_VOTO:   estado_d = LIMPA_PULAR;
            LIMPA_PULAR:   estado_d = AVALIA_DIA;
            AVALIA_DIA: begin
                if (acertou) begin
                    estado_d = FIM_VILA;
                end else if (sinal_lobo_ganhou) begin
                    estado_d = FIM_LOBO;
                end else begin
                    estado_d = NOVA_NOITE;
                end
            end
            NOVA_NOITE:    estado_d = NOITE_MOSTRA;
            FIM_VILA:      if (iniciar) estado_d = INICIAL;
            FIM_LOBO:      if (iniciar) estado_d = INICIAL;
            default:       estado_d = INICIAL;
        endcase
    end

    // Output decode; inc_jogador is the only strobe qualified by an input (CJ_fim)
    always_comb begin
        rst_global         = 1'b0;
        zera_CS            = 1'b0;
        zera_CJ            = 1'b0;
        inc_seed           = 1'b0;
        e_seed_reg         = 1'b0;
        inc_jogador        = 1'b0;
        mostra_classe      = 1'b0;
        processar_acao     = 1'b0;
        avaliar_eliminacao = 1'b0;
        voto               = 1'b0;
        morra              = 1'b0;
        reset_Pular        = 1'b0;
        fim_jogo           = 1'b0;
        vila_ganhou        = 1'b0;
        lobo_ganhou        = 1'b0;
        unique case (estado_q)
            INICIAL: begin
                rst_global = 1'b1;
                zera_CS    = 1'b1;
                zera_CJ    = 1'b1;
            end
            OCIOSO:        inc_seed = 1'b1;
            SEMENTE: begin
                e_seed_reg = 1'b1;
                zera_CJ    = 1'b1;
            end
            NOITE_MOSTRA:  mostra_classe = 1'b1;
            NOITE_ACAO: begin
                mostra_classe  = 1'b1;
                processar_acao = 1'b1;
            end
            NOITE_PROXIMO: inc_jogador = !CJ_fim;
            ELIMINA: begin
                avaliar_eliminacao = 1'b1;
                zera_CJ            = 1'b1;
            end
            REGISTRA_VOTO: voto = 1'b1;
            APLICA_VOTO:   morra = 1'b1;
            LIMPA_PULAR:   reset_Pular = 1'b1;
            NOVA_NOITE:    zera_CJ = 1'b1;
            FIM_VILA: begin
                fim_jogo    = 1'b1;
                vila_ganhou = 1'b1;
            end
            FIM_LOBO: begin
                fim_jogo    = 1'b1;
                lobo_ganhou = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estado_q;

endmodule
